// File: rtl/reg_arb_pkg.sv
// Shared types for the register-bus arbiter: FSM states and watchdog sizing.
// No logic of its own; latency and backpressure are defined by the users.
// The watchdog only ever holds 0..TIMEOUT-1, so it needs $clog2(TIMEOUT) bits.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic int wdog_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests past last_grant, take the lowest set bit, rotate back.
// Latency: purely combinational, zero cycles.
// Backpressure: none; gnt is all-zero when no request is pending.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    function automatic int wrap(input int v);
        return (v >= N_REQ) ? v - N_REQ : v;
    endfunction

    logic [N_REQ-1:0] rot;
    logic             found;
    int               off;

    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < N_REQ; j++) begin
            rot[j] = req[IW'(wrap(int'(last_grant) + 1 + j))];
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        gnt_idx = IW'(wrap(int'(last_grant) + 1 + off));
        gnt     = found ? (N_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer sharing one register bus between N_REQ requesters, with ack watchdog.
// Latency: accept T -> bus_valid T+1; ack A -> rsp_valid A+1 -> next accept A+2.
// Backpressure: one transaction in flight; req_ready is low outside IDLE, requests hold until accepted.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       bus_valid,
    output logic                       bus_write,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_ack,
    input  logic [DATA_W-1:0]          bus_rdata,
    input  logic                       bus_err,
    output logic                       stat_timeout
);

    localparam int              IW      = $clog2(N_REQ);
    localparam int              WW      = wdog_width(TIMEOUT);
    localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LG_RST  = IW'(N_REQ - 1);

    arb_state_e       state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    owner;
    logic [WW-1:0]    wdog;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx)
    );

    // Gated by rst_n so every output reads zero while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? pick_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= LG_RST;
            owner        <= '0;
            wdog         <= '0;
            bus_valid    <= 1'b0;
            bus_write    <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            stat_timeout <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|pick_gnt) begin
                        owner     <= pick_idx;
                        bus_valid <= 1'b1;
                        bus_write <= req_write[pick_idx];
                        bus_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        bus_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        wdog      <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack on the last allowed cycle beats the watchdog.
                    if (bus_ack) begin
                        bus_valid <= 1'b0;
                        rsp_valid <= N_REQ'(1) << owner;
                        rsp_rdata <= bus_rdata;
                        rsp_err   <= bus_err;
                        state     <= RESP;
                    end else if (wdog == WD_LAST) begin
                        bus_valid    <= 1'b0;
                        rsp_valid    <= N_REQ'(1) << owner;
                        rsp_rdata    <= '0;
                        rsp_err      <= 1'b1;
                        stat_timeout <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter (N_REQ=4, TIMEOUT=8): directed scenarios plus a randomized run
// checked against a transaction-level model of grant order, response data and the sticky timeout flag.
module tb_reg_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, bus_wdata, bus_rdata;
    logic [AW-1:0]   bus_addr;
    logic            rsp_err, bus_valid, bus_write, bus_ack, bus_err, stat_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    reg_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached at cycle %0d, required end of test", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    endtask

    task automatic rst_pulse();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        req_valid = 4'b0011;
        step();
        step();
        n_cmp++;
        if ({bus_valid, bus_write, bus_addr, bus_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_bus got v=%b a=%h d=%h required all 0", bus_valid, bus_addr, bus_wdata);
        end
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err, stat_timeout, req_ready} !== '0) begin
            n_bad++; $display("FAIL reset_rsp got rv=%b rd=%h e=%b st=%b rdy=%b required all 0",
                              rsp_valid, rsp_rdata, rsp_err, stat_timeout, req_ready);
        end
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        clear_inputs();
        set_req(1, 1'b0, 16'h0010, 32'h0);
        req_valid[1] = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL single_read_ready got %b required 0010", req_ready);
        end
        step();
        req_valid = '0;
        n_cmp++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 16'h0010) begin
            n_bad++; $display("FAIL single_read_bus got v=%b w=%b a=%h required 1 0 0010", bus_valid, bus_write, bus_addr);
        end
        step();
        step();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; bus_err = 1'b0;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || bus_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_read_rsp got rv=%b rd=%h e=%b bv=%b required 0010 deadbeef 0 0",
                              rsp_valid, rsp_rdata, rsp_err, bus_valid);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin
            n_bad++; $display("FAIL single_read_pulse got rv=%b required 0000", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int last_acc;
        rst_pulse();
        for (int r = 0; r < N; r++) set_req(r, 1'b0, AW'(16'h0100 + r), '0);
        req_valid = 4'b1111;
        last_acc = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << (k % N))) begin
                n_bad++; $display("FAIL rr_grant_%0d got %b required %b", k, req_ready, 4'b0001 << (k % N));
            end
            if (last_acc >= 0) begin
                n_cmp++;
                if (cyc - last_acc != 3) begin
                    n_bad++; $display("FAIL rr_spacing_%0d got %0d cycles required 3", k, cyc - last_acc);
                end
            end
            last_acc = cyc;
            step();
            n_cmp++;
            if (req_ready !== 4'b0000 || bus_addr !== AW'(16'h0100 + (k % N))) begin
                n_bad++; $display("FAIL rr_busy_%0d got rdy=%b a=%h required 0000 %h", k, req_ready, bus_addr, 16'h0100 + (k % N));
            end
            bus_ack = 1'b1; bus_rdata = DW'(k);
            step();
            bus_ack = 1'b0;
            n_cmp++;
            if (rsp_valid !== (4'b0001 << (k % N)) || rsp_rdata !== DW'(k)) begin
                n_bad++; $display("FAIL rr_rsp_%0d got rv=%b rd=%h required %b %h", k, rsp_valid, rsp_rdata, 4'b0001 << (k % N), k);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_ack_race();
        logic e;
        logic [DW-1:0] d;
        rst_pulse();
        set_req(0, 1'b0, 16'h0042, '0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int c = 1; c < TMO; c++) step();
        n_cmp++;
        if (bus_valid !== 1'b1) begin
            n_bad++; $display("FAIL race_still_busy got bus_valid=%b required 1 on BUSY cycle %0d", bus_valid, TMO);
        end
        e = 1'($urandom_range(0, 1));
        d = $urandom;
        bus_ack = 1'b1; bus_err = e; bus_rdata = d;
        step();
        bus_ack = 1'b0; bus_err = 1'b0;
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rsp_err !== e || rsp_rdata !== d || stat_timeout !== 1'b0) begin
            n_bad++; $display("FAIL race_rsp got rv=%b e=%b rd=%h st=%b required 0001 %b %h 0",
                              rsp_valid, rsp_err, rsp_rdata, stat_timeout, e, d);
        end
        step();
    endtask

    task automatic test_write_err();
        clear_inputs();
        set_req(3, 1'b1, 16'h00FF, 32'h12345678);
        set_req(0, 1'b0, 16'hAAAA, 32'hBBBBBBBB);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0001;
        set_req(3, 1'b0, 16'h1111, 32'h22222222);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (bus_valid !== 1'b1 || bus_write !== 1'b1 || bus_addr !== 16'h00FF || bus_wdata !== 32'h12345678) begin
                n_bad++; $display("FAIL wr_stable_c%0d got v=%b w=%b a=%h d=%h required 1 1 00ff 12345678",
                                  c, bus_valid, bus_write, bus_addr, bus_wdata);
            end
            if (c == 4) begin bus_ack = 1'b1; bus_err = 1'b1; end
            step();
        end
        bus_ack = 1'b0; bus_err = 1'b0; req_valid = '0;
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1) begin
            n_bad++; $display("FAIL wr_err_rsp got rv=%b e=%b required 1000 1", rsp_valid, rsp_err);
        end
        step();
    endtask

    task automatic test_timeout();
        int cnt;
        clear_inputs();
        set_req(2, 1'b0, 16'h0BAD, '0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        bus_rdata = 32'hFFFF_FFFF;
        cnt = 0;
        while (bus_valid === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        n_cmp++;
        if (cnt != TMO) begin
            n_bad++; $display("FAIL tmo_busy_len got %0d cycles required %0d", cnt, TMO);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== '0 || stat_timeout !== 1'b1) begin
            n_bad++; $display("FAIL tmo_rsp got rv=%b e=%b rd=%h st=%b required 0100 1 0 1",
                              rsp_valid, rsp_err, rsp_rdata, stat_timeout);
        end
        step();
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        n_cmp++;
        if (rsp_valid !== 4'b0000 || bus_valid !== 1'b0 || stat_timeout !== 1'b1) begin
            n_bad++; $display("FAIL tmo_late_ack got rv=%b bv=%b st=%b required 0000 0 1", rsp_valid, bus_valid, stat_timeout);
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        set_req(1, 1'b1, 16'h0077, 32'h55);
        set_req(2, 1'b0, 16'h0222, '0);
        req_valid = 4'b0010;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_valid !== 1'b0 || rsp_valid !== 4'b0000 || stat_timeout !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid_busy got bv=%b rv=%b st=%b rdy=%b required 0 0000 0 0000",
                              bus_valid, rsp_valid, stat_timeout, req_ready);
        end
        step();
        rst_n = 1'b1;
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL rst_first_accept got rdy=%b required 0100", req_ready);
        end
        step();
        req_valid = '0;
        n_cmp++;
        if (bus_valid !== 1'b1 || bus_addr !== 16'h0222) begin
            n_bad++; $display("FAIL rst_first_bus got v=%b a=%h required 1 0222", bus_valid, bus_addr);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        step();
    endtask

    task automatic test_random();
        int m_last, w, lat;
        logic m_stat;
        logic [N-1:0] exp_rdy;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, rd;
        logic ew, ee;
        rst_pulse();
        m_last = N - 1;
        m_stat = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < N; r++) set_req(r, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            req_valid = N'($urandom_range(0, 15));
            #1;
            w = -1;
            for (int i = 1; i <= N; i++) begin
                if (w < 0 && req_valid[(m_last + i) % N]) w = (m_last + i) % N;
            end
            exp_rdy = (w < 0) ? '0 : (N'(1) << w);
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_bad++; $display("FAIL rnd_ready_%0d got %b required %b", t, req_ready, exp_rdy);
            end
            if (w < 0) begin
                step();
                continue;
            end
            ea = req_addr[w*AW +: AW];
            ed = req_wdata[w*DW +: DW];
            ew = req_write[w];
            step();
            req_valid = N'($urandom_range(0, 15));
            set_req(w, ~ew, ~ea, ~ed);
            n_cmp++;
            if (bus_valid !== 1'b1 || bus_addr !== ea || bus_wdata !== ed || bus_write !== ew) begin
                n_bad++; $display("FAIL rnd_bus_%0d got v=%b a=%h d=%h w=%b required 1 %h %h %b",
                                  t, bus_valid, bus_addr, bus_wdata, bus_write, ea, ed, ew);
            end
            lat = $urandom_range(1, TMO + 2);
            rd = '0;
            ee = 1'b1;
            for (int c = 1; c <= TMO; c++) begin
                if (c == lat) begin
                    rd = $urandom;
                    ee = 1'($urandom_range(0, 1));
                    bus_ack = 1'b1; bus_rdata = rd; bus_err = ee;
                end else begin
                    bus_rdata = $urandom;
                end
                step();
                bus_ack = 1'b0;
                if (c == lat) break;
            end
            if (lat > TMO) m_stat = 1'b1;
            n_cmp++;
            if (rsp_valid !== (N'(1) << w) || rsp_rdata !== rd || rsp_err !== ee || stat_timeout !== m_stat) begin
                n_bad++; $display("FAIL rnd_rsp_%0d got rv=%b rd=%h e=%b st=%b required %b %h %b %b",
                                  t, rsp_valid, rsp_rdata, rsp_err, stat_timeout, N'(1) << w, rd, ee, m_stat);
            end
            m_last = w;
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_ack_race();
        test_write_err();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
